// File: rtl/team_06_fx_sequencer.sv
// ---------------------------------------------------------------------------
// team_06_fx_sequencer
// Per-sample controller for the audio effect chain. Each sample strobe latches
// one 8-bit sample and walks it through every enabled effect slot in fixed
// order 0..N_FX-1 over a shared req/ack datapath, then presents the result to
// the output stage.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   sample_tick  1-cycle strobe, new sample on sample_in
//   sample_in    raw 8-bit audio sample
//   fx_en        per-slot enable, captured with sample_tick
//   fx_req       one-hot request to the slot owning the datapath
//   fx_data_out  current accumulated sample, broadcast to all slots
//   fx_ack       per-slot result ready (only the requested slot is honoured)
//   fx_data_in   slot results, slot i at [8*i+7:8*i]
//   sample_out   processed sample, held until the next completion
//   sample_valid 1-cycle pulse when sample_out updates
//   busy         high whenever the sequencer is not idle
//   overrun      sticky, a tick arrived while busy
//   fx_timeout   sticky per slot, slot bypassed because it never answered
//   clear_flags  synchronous clear of overrun and fx_timeout
// ---------------------------------------------------------------------------
module team_06_fx_sequencer #(
   parameter int N_FX    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_tick,
   input  logic [7:0]        sample_in,
   input  logic [N_FX-1:0]   fx_en,
   output logic [N_FX-1:0]   fx_req,
   output logic [7:0]        fx_data_out,
   input  logic [N_FX-1:0]   fx_ack,
   input  logic [8*N_FX-1:0] fx_data_in,
   output logic [7:0]        sample_out,
   output logic              sample_valid,
   output logic              busy,
   output logic              overrun,
   output logic [N_FX-1:0]   fx_timeout,
   input  logic              clear_flags
);

   localparam int SW = (N_FX > 1) ? $clog2(N_FX) : 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

   state_t          state;
   state_t          state_next;
   logic [SW-1:0]   slot;
   logic [TW-1:0]   timer;
   logic [7:0]      acc;
   logic [7:0]      acc_next;
   logic [N_FX-1:0] mask;

   logic            last_slot;
   logic            slot_ack;
   logic            slot_expired;
   logic [7:0]      slot_result;

   // Only the bit of the slot currently being served is ever looked at, so a
   // stray ack from any other slot cannot advance the sequence.
   assign last_slot    = (slot == SW'(N_FX - 1));
   assign slot_ack     = fx_ack[slot];
   assign slot_expired = !slot_ack && (timer == TW'(TIMEOUT - 1));
   assign slot_result  = fx_data_in[8*int'(slot) +: 8];
   assign fx_data_out  = acc;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. acc_next is resolved here too so that the completion
   // cycle can publish the value a slot returns on the very edge it acks.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      case (state)
         IDLE: begin
            if (sample_tick) begin
               state_next = SCAN;
               acc_next   = sample_in;
            end
         end
         SCAN: begin
            if (mask[slot]) begin
               state_next = WAIT;
            end else if (last_slot) begin
               state_next = DONE;
            end
         end
         WAIT: begin
            if (slot_ack) begin
               acc_next = slot_result;
            end
            if (slot_ack || slot_expired) begin
               state_next = last_slot ? DONE : SCAN;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Registered outputs and datapath. sample_out/sample_valid are loaded on
   // entry to DONE so that the pulse is visible during the DONE cycle itself.
   // clear_flags is applied last so it wins over a same-cycle flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fx_req       <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         fx_timeout   <= '0;
         slot         <= '0;
         timer        <= '0;
         acc          <= '0;
         mask         <= '0;
      end else begin
         sample_valid <= 1'b0;
         busy         <= (state_next != IDLE);
         acc          <= acc_next;
         case (state)
            IDLE: begin
               if (sample_tick) begin
                  mask <= fx_en;
                  slot <= '0;
               end
            end
            SCAN: begin
               if (mask[slot]) begin
                  fx_req <= N_FX'(1) << slot;
                  timer  <= '0;
               end else if (!last_slot) begin
                  slot <= slot + SW'(1);
               end
            end
            WAIT: begin
               if (slot_ack || slot_expired) begin
                  fx_req <= '0;
                  if (!slot_ack) begin
                     fx_timeout[slot] <= 1'b1;
                  end
                  if (!last_slot) begin
                     slot <= slot + SW'(1);
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
            end
         endcase
         if (state_next == DONE) begin
            sample_out   <= acc_next;
            sample_valid <= 1'b1;
         end
         if (sample_tick && (state != IDLE)) begin
            overrun <= 1'b1;
         end
         if (clear_flags) begin
            overrun    <= 1'b0;
            fx_timeout <= '0;
         end
      end
   end

endmodule

// File: tb/tb_team_06_fx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_team_06_fx_sequencer
// Directed bench for the effect sequencer. A small responder models the effect
// slots: each slot has a mode (silent, constant, +1, invert) and answers in the
// first cycle its request is seen. Inputs change on the falling edge, outputs
// are checked on the falling edge. Cycle c counts from the edge that took the
// tick (c=1 is the cycle right after that edge).
// ---------------------------------------------------------------------------
module tb_team_06_fx_sequencer;

   logic        clk;
   logic        rst;
   logic        sample_tick;
   logic [7:0]  sample_in;
   logic [3:0]  fx_en;
   logic [3:0]  fx_req;
   logic [7:0]  fx_data_out;
   logic [3:0]  fx_ack;
   logic [31:0] fx_data_in;
   logic [7:0]  sample_out;
   logic        sample_valid;
   logic        busy;
   logic        overrun;
   logic [3:0]  fx_timeout;
   logic        clear_flags;

   logic [3:0]  stray_ack;
   int          resp_mode [4];
   int          checks;
   int          failures;

   team_06_fx_sequencer #(.N_FX(4), .TIMEOUT(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_tick  (sample_tick),
      .sample_in    (sample_in),
      .fx_en        (fx_en),
      .fx_req       (fx_req),
      .fx_data_out  (fx_data_out),
      .fx_ack       (fx_ack),
      .fx_data_in   (fx_data_in),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun),
      .fx_timeout   (fx_timeout),
      .clear_flags  (clear_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behaviour of one effect slot given its mode and the broadcast sample.
   function automatic logic [7:0] slot_model(int mode, logic [7:0] x);
      case (mode)
         1:       return 8'h72;
         2:       return x + 8'd1;
         3:       return x ^ 8'hFF;
         default: return x;
      endcase
   endfunction

   // Slot responder: ack the requested slot immediately unless it is silent,
   // and overlay any stray ack the scenario wants on other slots.
   task automatic respond();
      logic [3:0]  a;
      logic [31:0] d;
      a = stray_ack;
      d = fx_data_in;
      if (stray_ack[2]) d[23:16] = 8'hEE;
      for (int i = 0; i < 4; i++) begin
         if (fx_req[i] && resp_mode[i] != 0) begin
            a[i] = 1'b1;
            d[8*i +: 8] = slot_model(resp_mode[i], fx_data_out);
         end
      end
      fx_ack     = a;
      fx_data_in = d;
   endtask

   // Move to the falling edge of the next cycle and refresh the responder.
   task automatic adv();
      @(negedge clk);
      respond();
   endtask

   // Present a tick across one rising edge, then scramble fx_en to show that
   // later enable changes are ignored for the sample in flight.
   task automatic tick_at(input logic [7:0] s, input logic [3:0] en);
      @(negedge clk);
      sample_in   = s;
      fx_en       = en;
      sample_tick = 1'b1;
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
      fx_en       = 4'hF;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_flags = 1'b1;
      @(posedge clk);
      #1;
      clear_flags = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (fx_req !== 4'h0) begin failures++; $display("[TB] FAIL reset_fx_req got=%h exp=0", fx_req); end
      checks++; if (fx_data_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_fx_data_out got=%h exp=00", fx_data_out); end
      checks++; if (sample_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_sample_out got=%h exp=00", sample_out); end
      checks++; if (sample_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_sample_valid got=%b exp=0", sample_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
      checks++; if (fx_timeout !== 4'h0) begin failures++; $display("[TB] FAIL reset_fx_timeout got=%h exp=0", fx_timeout); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_bypass_all();
      tick_at(8'hE5, 4'b0000);
      for (int c = 1; c <= 8; c++) begin
         adv();
         checks++; if (sample_valid !== 1'(c == 5)) begin failures++; $display("[TB] FAIL bypass_valid c=%0d got=%b exp=%b", c, sample_valid, c == 5); end
         checks++; if (fx_req !== 4'h0) begin failures++; $display("[TB] FAIL bypass_req c=%0d got=%h exp=0", c, fx_req); end
         checks++; if (busy !== 1'(c <= 5)) begin failures++; $display("[TB] FAIL bypass_busy c=%0d got=%b exp=%b", c, busy, c <= 5); end
         if (c == 5) begin
            checks++; if (sample_out !== 8'hE5) begin failures++; $display("[TB] FAIL bypass_out got=%h exp=e5", sample_out); end
         end
      end
   endtask

   task automatic test_single_slot();
      resp_mode = '{1, 0, 0, 0};
      tick_at(8'h11, 4'b0001);
      for (int c = 1; c <= 9; c++) begin
         adv();
         checks++; if (fx_req !== ((c == 2) ? 4'b0001 : 4'b0000)) begin failures++; $display("[TB] FAIL single_req c=%0d got=%h", c, fx_req); end
         checks++; if (sample_valid !== 1'(c == 6)) begin failures++; $display("[TB] FAIL single_valid c=%0d got=%b exp=%b", c, sample_valid, c == 6); end
         if (c == 2) begin
            checks++; if (fx_data_out !== 8'h11) begin failures++; $display("[TB] FAIL single_bcast got=%h exp=11", fx_data_out); end
         end
         if (c == 6) begin
            checks++; if (sample_out !== 8'h72) begin failures++; $display("[TB] FAIL single_out got=%h exp=72", sample_out); end
         end
      end
   endtask

   task automatic test_two_slots();
      logic [3:0] exp_req;
      resp_mode = '{0, 2, 0, 3};
      tick_at(8'h04, 4'b1010);
      for (int c = 1; c <= 10; c++) begin
         adv();
         exp_req = (c == 3) ? 4'b0010 : (c == 6) ? 4'b1000 : 4'b0000;
         checks++; if (fx_req !== exp_req) begin failures++; $display("[TB] FAIL two_req c=%0d got=%h exp=%h", c, fx_req, exp_req); end
         checks++; if (sample_valid !== 1'(c == 7)) begin failures++; $display("[TB] FAIL two_valid c=%0d got=%b exp=%b", c, sample_valid, c == 7); end
         if (c == 3) begin
            checks++; if (fx_data_out !== 8'h04) begin failures++; $display("[TB] FAIL two_bcast1 got=%h exp=04", fx_data_out); end
         end
         if (c == 6) begin
            checks++; if (fx_data_out !== 8'h05) begin failures++; $display("[TB] FAIL two_bcast3 got=%h exp=05", fx_data_out); end
         end
         if (c == 7) begin
            checks++; if (sample_out !== 8'hFA) begin failures++; $display("[TB] FAIL two_out got=%h exp=fa", sample_out); end
         end
      end
   endtask

   task automatic test_timeout();
      logic [3:0] exp_req;
      resp_mode = '{0, 0, 0, 0};
      tick_at(8'h5A, 4'b0100);
      for (int c = 1; c <= 72; c++) begin
         adv();
         exp_req = (c >= 4 && c <= 67) ? 4'b0100 : 4'b0000;
         checks++; if (fx_req !== exp_req) begin failures++; $display("[TB] FAIL tmo_req c=%0d got=%h exp=%h", c, fx_req, exp_req); end
         if (c == 67) begin
            checks++; if (fx_timeout !== 4'b0000) begin failures++; $display("[TB] FAIL tmo_early got=%h exp=0", fx_timeout); end
         end
         if (c == 68) begin
            checks++; if (fx_timeout !== 4'b0100) begin failures++; $display("[TB] FAIL tmo_flag got=%h exp=4", fx_timeout); end
         end
         checks++; if (sample_valid !== 1'(c == 69)) begin failures++; $display("[TB] FAIL tmo_valid c=%0d got=%b exp=%b", c, sample_valid, c == 69); end
         if (c == 69) begin
            checks++; if (sample_out !== 8'h5A) begin failures++; $display("[TB] FAIL tmo_out got=%h exp=5a", sample_out); end
         end
      end
      pulse_clear();
      @(negedge clk);
      checks++; if (fx_timeout !== 4'b0000) begin failures++; $display("[TB] FAIL tmo_clear got=%h exp=0", fx_timeout); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL tmo_overrun got=%b exp=0", overrun); end
   endtask

   task automatic test_back_to_back();
      logic exp_ovr;
      resp_mode = '{2, 0, 0, 0};
      tick_at(8'h30, 4'b0001);
      for (int c = 1; c <= 12; c++) begin
         adv();
         exp_ovr = (c == 2 || c == 3 || c >= 7);
         checks++; if (fx_req !== ((c == 2) ? 4'b0001 : 4'b0000)) begin failures++; $display("[TB] FAIL b2b_req c=%0d got=%h", c, fx_req); end
         checks++; if (sample_valid !== 1'(c == 6)) begin failures++; $display("[TB] FAIL b2b_valid c=%0d got=%b exp=%b", c, sample_valid, c == 6); end
         checks++; if (overrun !== exp_ovr) begin failures++; $display("[TB] FAIL b2b_overrun c=%0d got=%b exp=%b", c, overrun, exp_ovr); end
         checks++; if (busy !== 1'(c <= 6)) begin failures++; $display("[TB] FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, c <= 6); end
         if (c == 2) begin
            checks++; if (fx_data_out !== 8'h30) begin failures++; $display("[TB] FAIL b2b_acc got=%h exp=30", fx_data_out); end
         end
         if (c == 6) begin
            checks++; if (sample_out !== 8'h31) begin failures++; $display("[TB] FAIL b2b_out got=%h exp=31", sample_out); end
         end
         case (c)
            1: begin sample_tick = 1'b1; sample_in = 8'h99; stray_ack = 4'b0100; end
            2: sample_tick = 1'b0;
            3: begin sample_tick = 1'b1; clear_flags = 1'b1; end
            4: begin sample_tick = 1'b0; clear_flags = 1'b0; end
            6: begin sample_tick = 1'b1; stray_ack = 4'b0000; end
            7: sample_tick = 1'b0;
            default: ;
         endcase
      end
      checks++; if (fx_timeout !== 4'b0000) begin failures++; $display("[TB] FAIL b2b_timeout got=%h exp=0", fx_timeout); end
      pulse_clear();
   endtask

   task automatic test_reset_mid_wait();
      resp_mode = '{0, 0, 0, 0};
      tick_at(8'h42, 4'b0001);
      adv();
      adv();
      checks++; if (fx_req !== 4'b0001) begin failures++; $display("[TB] FAIL rmw_req_before got=%h exp=1", fx_req); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (fx_req !== 4'b0000) begin failures++; $display("[TB] FAIL rmw_req got=%h exp=0", fx_req); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rmw_busy got=%b exp=0", busy); end
      checks++; if (fx_data_out !== 8'h00) begin failures++; $display("[TB] FAIL rmw_acc got=%h exp=00", fx_data_out); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         adv();
         checks++; if (sample_valid !== 1'b0 || fx_req !== 4'b0000) begin failures++; $display("[TB] FAIL rmw_idle c=%0d valid=%b req=%h exp=0/0", c, sample_valid, fx_req); end
      end
      checks++; if (fx_timeout !== 4'b0000) begin failures++; $display("[TB] FAIL rmw_timeout got=%h exp=0", fx_timeout); end
      tick_at(8'h3C, 4'b0000);
      for (int c = 1; c <= 6; c++) begin
         adv();
         checks++; if (sample_valid !== 1'(c == 5)) begin failures++; $display("[TB] FAIL rmw_valid c=%0d got=%b exp=%b", c, sample_valid, c == 5); end
         if (c == 5) begin
            checks++; if (sample_out !== 8'h3C) begin failures++; $display("[TB] FAIL rmw_out got=%h exp=3c", sample_out); end
         end
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b0;
      sample_tick = 1'b0;
      sample_in   = 8'h00;
      fx_en       = 4'h0;
      fx_ack      = 4'h0;
      fx_data_in  = 32'h0;
      clear_flags = 1'b0;
      stray_ack   = 4'h0;
      resp_mode   = '{0, 0, 0, 0};
      test_reset();
      test_bypass_all();
      test_single_slot();
      test_two_slots();
      test_timeout();
      test_back_to_back();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
